// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (PARITY_ODD selects polarity).
module uart_tx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
        CLKS_PER_BIT < 2 || !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_params
        $error("uart_tx_framer: illegal parameter combination");
    end

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    wire cnt_last = (cnt_q == CNT_LAST);

    // tx_d always carries the line value of the state being entered, so tx stays registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = '0;
                if (valid) begin
                    shift_d = data;
                    state_d = S_START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            S_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = ~ready;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: reset, framing, back-to-back pitch, busy-ignore, mid-frame reset,
// 9-bit words and (with UART_TX_PARITY_EN) parity polarity.
module tb_uart_tx_framer;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F8 = C * (1 + 8 + P + 1);

    logic clk, rst;
    logic       valid0, ready0, busy0, tx0;
    logic [7:0] data0;
    logic       valid9, ready9, busy9, tx9;
    logic [8:0] data9;
    logic       tx7e, ready7e, busy7e, tx7o, ready7o, busy7o;
`ifdef UART_TX_PARITY_EN
    logic       valid7;
    logic [6:0] data7;
`endif

    int vectors = 0;
    int miscompares = 0;
    int sel;
    int cyc = 0;
    int t1, t2;
    logic tx_m, rdy_m, busy_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(C), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .valid(valid0), .data(data0),
        .ready(ready0), .busy(busy0), .tx(tx0));

    uart_tx_framer #(.DATA_BITS(9), .STOP_BITS(1), .CLKS_PER_BIT(C), .PARITY_ODD(0)) dut9 (
        .clk(clk), .rst(rst), .valid(valid9), .data(data9),
        .ready(ready9), .busy(busy9), .tx(tx9));

`ifdef UART_TX_PARITY_EN
    uart_tx_framer #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(C), .PARITY_ODD(0)) dut7e (
        .clk(clk), .rst(rst), .valid(valid7), .data(data7),
        .ready(ready7e), .busy(busy7e), .tx(tx7e));
    uart_tx_framer #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(C), .PARITY_ODD(1)) dut7o (
        .clk(clk), .rst(rst), .valid(valid7), .data(data7),
        .ready(ready7o), .busy(busy7o), .tx(tx7o));
`else
    assign tx7e = 1'b1;
    assign ready7e = 1'b1;
    assign busy7e = 1'b0;
    assign tx7o = 1'b1;
    assign ready7o = 1'b1;
    assign busy7o = 1'b0;
`endif

    always_comb begin
        case (sel)
            1:       begin tx_m = tx9;  rdy_m = ready9;  busy_m = busy9;  end
            2:       begin tx_m = tx7e; rdy_m = ready7e; busy_m = busy7e; end
            3:       begin tx_m = tx7o; rdy_m = ready7o; busy_m = busy7o; end
            default: begin tx_m = tx0;  rdy_m = ready0;  busy_m = busy0;  end
        endcase
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits in time order: bit 0 is the start bit.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nb, input int par,
                                               input bit odd, input int stops);
        logic [15:0] f;
        logic        p;
        int          idx;
        f = '0;
        p = odd;
        for (int j = 0; j < nb; j++) begin
            f[1+j] = d[j];
            p = p ^ d[j];
        end
        idx = 1 + nb;
        if (par != 0) begin
            f[idx] = p;
            idx++;
        end
        for (int s = 0; s < stops; s++) f[idx+s] = 1'b1;
        return f;
    endfunction

    // Entered at the negedge of frame cycle 1; leaves at the negedge of cycle F+1.
    task automatic frame_check(input logic [15:0] eb, input int nbits, input string tag,
                               input int pulse_k);
        for (int k = 0; k < nbits * C; k++) begin
            if (pulse_k >= 0 && k == pulse_k) begin
                valid0 = 1'b1;
                data0  = 8'h12;
            end else if (pulse_k >= 0 && k == pulse_k + 1) begin
                valid0 = 1'b0;
            end
            chk(32'(tx_m), 32'(eb[k/C]), {tag, ".tx"});
            chk(32'(rdy_m), 32'd0, {tag, ".ready"});
            chk(32'(busy_m), 32'd1, {tag, ".busy"});
            @(negedge clk);
        end
        chk(32'(rdy_m), 32'd1, {tag, ".ready_end"});
        chk(32'(tx_m), 32'd1, {tag, ".tx_end"});
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        valid0 = 1'b0; data0 = '0;
        valid9 = 1'b0; data9 = '0;
`ifdef UART_TX_PARITY_EN
        valid7 = 1'b0; data7 = '0;
`endif
        repeat (3) begin
            @(negedge clk);
            chk(32'(tx0), 32'd1, "reset.tx");
            chk(32'(ready0), 32'd1, "reset.ready");
            chk(32'(busy0), 32'd0, "reset.busy");
        end
        rst = 1'b0;
        @(negedge clk);
        chk(32'(tx0), 32'd1, "post_reset.tx");
        chk(32'(ready0), 32'd1, "post_reset.ready");

        // Single frame 0xA5
        valid0 = 1'b1; data0 = 8'hA5;
        @(negedge clk);
        valid0 = 1'b0;
`ifdef UART_TX_PARITY_EN
        frame_check(frame_bits(9'h0A5, 8, 1, 1'b0, 1), 11, "a5", -1);
`else
        frame_check(16'b0000_0011_0100_1010, 10, "a5", -1);
`endif

        // Back-to-back with valid held: 0x00 then 0xFF
        valid0 = 1'b1; data0 = 8'h00;
        @(negedge clk);
        t1 = cyc;
        data0 = 8'hFF;
        frame_check(frame_bits(9'h000, 8, P, 1'b0, 1), 10 + P, "b2b0", -1);
        @(negedge clk);
        t2 = cyc;
        valid0 = 1'b0;
        chk(32'(t2 - t1), 32'(F8 + 1), "b2b.pitch");
        frame_check(frame_bits(9'h0FF, 8, P, 1'b0, 1), 10 + P, "b2b1", -1);

        // valid pulsed with 0x12 while busy must be ignored
        valid0 = 1'b1; data0 = 8'h3C;
        @(negedge clk);
        valid0 = 1'b0;
        frame_check(frame_bits(9'h03C, 8, P, 1'b0, 1), 10 + P, "ignore", 20);
        repeat (4) begin
            @(negedge clk);
            chk(32'(tx0), 32'd1, "ignore.idle_tx");
            chk(32'(ready0), 32'd1, "ignore.idle_ready");
        end

        // Reset in cycle 18 of a 0x55 frame, with a simultaneous offered word
        valid0 = 1'b1; data0 = 8'h55;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (17) @(negedge clk);
        chk(32'(tx0), 32'd0, "abort.pre_rst_tx");
        rst = 1'b1; valid0 = 1'b1; data0 = 8'hF0;
        @(negedge clk);
        chk(32'(tx0), 32'd1, "abort.tx");
        chk(32'(ready0), 32'd1, "abort.ready");
        chk(32'(busy0), 32'd0, "abort.busy");
        @(negedge clk);
        chk(32'(ready0), 32'd1, "rst_priority.ready");
        chk(32'(tx0), 32'd1, "rst_priority.tx");
        rst = 1'b0; valid0 = 1'b0;
        @(negedge clk);
        chk(32'(ready0), 32'd1, "post_abort.ready");
        chk(32'(tx0), 32'd1, "post_abort.tx");
        valid0 = 1'b1; data0 = 8'h0F;
        @(negedge clk);
        valid0 = 1'b0;
        frame_check(frame_bits(9'h00F, 8, P, 1'b0, 1), 10 + P, "after_abort", -1);

        // Nine-bit word of all ones
        sel = 1;
        valid9 = 1'b1; data9 = 9'h1FF;
        @(negedge clk);
        valid9 = 1'b0;
        frame_check(frame_bits(9'h1FF, 9, P, 1'b0, 1), 11 + P, "nine", -1);
        repeat (3) begin
            @(negedge clk);
            chk(32'(tx9), 32'd1, "nine.idle_tx");
        end

`ifdef UART_TX_PARITY_EN
        // 7 data bits, 2 stop bits, word 0x03: even parity 0, odd parity 1
        sel = 2;
        valid7 = 1'b1; data7 = 7'h03;
        @(negedge clk);
        valid7 = 1'b0;
        frame_check(16'b0000_0110_0000_0110, 11, "par_even", -1);
        sel = 3;
        valid7 = 1'b1; data7 = 7'h03;
        @(negedge clk);
        valid7 = 1'b0;
        frame_check(16'b0000_0111_0000_0110, 11, "par_odd", -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
